uart_frame_sched: RTL

Sequencing controller for the UART receive-buffer-transmit path. It writes each received byte into the 32-entry byte FIFO and detects end-of-frame as a line-idle gap measured in bit times. It then drains the FIFO into the UART transmitter one byte at a time under a start/busy handshake. It sits between the rx deserializer, the FIFO storage, and the tx serializer, and replaces ad-hoc RD/WR sequencing with a single explicit state machine.

---
 rtl/uart_frame_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: sequences rx bytes into a byte FIFO, closes a frame after
// IDLE_BITS idle bit times, then drains the FIFO into the UART transmitter.
// Optional sticky drop flag (overflow port) enabled by defining
// UART_FRAME_SCHED_OVERFLOW_EN.
module uart_frame_sched #(
    parameter int DEPTH        = 32,
    parameter int AW           = 5,
    parameter int CLKS_PER_BIT = 1252,
    parameter int IDLE_BITS    = 960
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    output logic          fifo_wr,
    output logic [7:0]    fifo_wdata,
    output logic          fifo_rd,
    input  logic [7:0]    fifo_rdata,
    input  logic [AW:0]   fifo_count,
    output logic          tx_start,
    output logic [7:0]    tx_byte,
    input  logic          tx_busy,
    output logic [1:0]    state,
`ifdef UART_FRAME_SCHED_OVERFLOW_EN
    output logic          overflow,
`endif
    output logic [AW:0]   frame_len
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = $clog2(IDLE_BITS + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TICK_C  = TW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] IDLE_C  = GW'(IDLE_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FETCH   = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t        fsm;
    logic [1:0]    step;
    logic [TW-1:0] tick_cnt;
    logic [GW-1:0] gap;
    logic          tick;
    logic          accept;
    logic          wr_pending;

    assign tick       = (tick_cnt == TICK_C);
    assign accept     = rx_valid && (fifo_count < DEPTH_C);
    // A write is in flight if the strobe is up now or an accepted byte arrives now.
    assign wr_pending = fifo_wr || accept;
    assign state      = fsm;

    // Free-running bit-time counter; tick marks the wrap.
    always_ff @(posedge clock) begin
        if (!reset)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // Write path: accepted bytes reach the FIFO one cycle after rx_valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fifo_wr    <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            fifo_wr <= accept;
            if (accept) fifo_wdata <= rx_byte;
        end
    end

    // Frame sequencer: collect, detect idle gap, then drain one byte per handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm       <= IDLE;
            step      <= '0;
            gap       <= '0;
            frame_len <= '0;
            fifo_rd   <= 1'b0;
            tx_start  <= 1'b0;
            tx_byte   <= '0;
        end else begin
            fifo_rd  <= 1'b0;
            tx_start <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (rx_valid) begin
                        fsm       <= COLLECT;
                        frame_len <= accept ? (AW + 1)'(1) : '0;
                        gap       <= '0;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        gap <= '0;
                        if (accept && frame_len < DEPTH_C)
                            frame_len <= frame_len + (AW + 1)'(1);
                    end else if (gap == IDLE_C) begin
                        fsm  <= FETCH;
                        step <= '0;
                    end else if (tick) begin
                        gap <= gap + GW'(1);
                    end
                end
                FETCH: begin
                    case (step)
                        2'd0: begin
                            // Read only a non-empty FIFO; wait out a write still in flight.
                            if (fifo_count != '0) begin
                                if (!tx_busy) begin
                                    fifo_rd <= 1'b1;
                                    step    <= 2'd1;
                                end
                            end else if (!wr_pending) begin
                                fsm <= IDLE;
                            end
                        end
                        2'd1: step <= 2'd2;
                        default: begin
                            tx_byte  <= fifo_rdata;
                            tx_start <= 1'b1;
                            fsm      <= SEND;
                            step     <= '0;
                        end
                    endcase
                end
                SEND: begin
                    // tx_busy is not yet meaningful in the start cycle and the one after.
                    if (step != 2'd2) begin
                        step <= step + 2'd1;
                    end else if (!tx_busy) begin
                        fsm  <= FETCH;
                        step <= '0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef UART_FRAME_SCHED_OVERFLOW_EN
    logic drop;
    assign drop = rx_valid && !accept;

    // Sticky drop flag; a new frame restarts it from the state of its first byte.
    always_ff @(posedge clock) begin
        if (!reset)                      overflow <= 1'b0;
        else if (fsm == IDLE && rx_valid) overflow <= drop;
        else if (drop)                   overflow <= 1'b1;
    end
`endif

endmodule
